// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder.
// Opcodes, error codes, format tags and the field bundle.
package instr_encoder_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [1:0] {
        ERR_OPCODE = 2'd0,
        ERR_RANGE  = 2'd1,
        ERR_ALIGN  = 2'd2,
        ERR_SHIFT  = 2'd3
    } err_code_t;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S,
        FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_t;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
    } fields_t;

    // True when v is the sign extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic [XLEN-1:0] v,
                                         input int bits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= bits && v[i] != v[bits-1]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational format select, bit packing and field checks.
// Misalignment is tested before range so it wins priority.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  fields_t         f,
    output logic [XLEN-1:0] word,
    output logic            err,
    output err_code_t       code
);

    fmt_t fmt;

    // Map the opcode (and shift funct3) onto an encoding format.
    always_comb begin
        fmt = FMT_BAD;
        unique case (f.opcode)
            OP_REG:            fmt = FMT_R;
            OP_IMM:            fmt = (f.funct3[1:0] == 2'b01) ? FMT_SH : FMT_I;
            OP_LOAD, OP_JALR:  fmt = FMT_I;
            OP_STORE:          fmt = FMT_S;
            OP_BRANCH:         fmt = FMT_B;
            OP_LUI, OP_AUIPC:  fmt = FMT_U;
            OP_JAL:            fmt = FMT_J;
            default:           fmt = FMT_BAD;
        endcase
    end

    // Pack the word for the chosen format and flag illegal fields.
    always_comb begin
        word = '0;
        err  = 1'b0;
        code = ERR_OPCODE;
        unique case (fmt)
            FMT_R: begin
                word = {f.funct7, f.rs2, f.rs1, f.funct3, f.rd, f.opcode};
            end
            FMT_I: begin
                word = {f.imm[11:0], f.rs1, f.funct3, f.rd, f.opcode};
                if (!fits_signed(f.imm, 12)) begin
                    err  = 1'b1;
                    code = ERR_RANGE;
                end
            end
            FMT_SH: begin
                word = {f.funct7, f.imm[4:0], f.rs1, f.funct3, f.rd, f.opcode};
                if (f.imm[XLEN-1:5] != '0
                    || !(f.funct7 == 7'h00 || f.funct7 == 7'h20)
                    || (f.funct3 == 3'b001 && f.funct7 != 7'h00)) begin
                    err  = 1'b1;
                    code = ERR_SHIFT;
                end
            end
            FMT_S: begin
                word = {f.imm[11:5], f.rs2, f.rs1, f.funct3,
                        f.imm[4:0], f.opcode};
                if (!fits_signed(f.imm, 12)) begin
                    err  = 1'b1;
                    code = ERR_RANGE;
                end
            end
            FMT_B: begin
                word = {f.imm[12], f.imm[10:5], f.rs2, f.rs1, f.funct3,
                        f.imm[4:1], f.imm[11], f.opcode};
                if (f.imm[0]) begin
                    err  = 1'b1;
                    code = ERR_ALIGN;
                end else if (!fits_signed(f.imm, 13)) begin
                    err  = 1'b1;
                    code = ERR_RANGE;
                end
            end
            FMT_U: begin
                word = {f.imm[31:12], f.rd, f.opcode};
                if (f.imm[11:0] != '0) begin
                    err  = 1'b1;
                    code = ERR_RANGE;
                end
            end
            FMT_J: begin
                word = {f.imm[20], f.imm[10:1], f.imm[11], f.imm[19:12],
                        f.rd, f.opcode};
                if (f.imm[0]) begin
                    err  = 1'b1;
                    code = ERR_ALIGN;
                end else if (!fits_signed(f.imm, 21)) begin
                    err  = 1'b1;
                    code = ERR_RANGE;
                end
            end
            default: begin
                err  = 1'b1;
                code = ERR_OPCODE;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage RV32I field encoder streaming words into IMEM.
// S1 checks/packs, S2 holds the word until memory takes it.
module instr_encoder
    import instr_encoder_pkg::fields_t, instr_encoder_pkg::err_code_t;
#(
    parameter int          XLEN      = 32,
    parameter int          IMEM_AW   = 14,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [2:0]         funct3,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic [6:0]         funct7,
    input  logic [XLEN-1:0]    imm,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_din,
    input  logic               imem_ready,
    output logic               err_valid,
    output logic [1:0]         err_code,
    output logic [15:0]        count
);

    localparam logic [IMEM_AW-1:0] BASE = IMEM_AW'(BASE_ADDR);

    fields_t         s1_f;
    logic            s1_valid;
    logic            s2_valid;
    logic [XLEN-1:0] pk_word;
    logic            pk_err;
    err_code_t       pk_code;
    logic            wr_done;
    logic            s2_adv;
    logic            s1_ret;
    logic            accept;
    logic            err_fire;

    instr_pack u_pack (
        .f    (s1_f),
        .word (pk_word),
        .err  (pk_err),
        .code (pk_code)
    );

    assign wr_done  = s2_valid & imem_ready;
    assign s2_adv   = !s2_valid | imem_ready;
    assign s1_ret   = s1_valid & (pk_err | s2_adv);
    assign in_ready = !flush & (!s1_valid | s1_ret);
    assign accept   = in_valid & in_ready;
    assign err_fire = !flush & s1_valid & pk_err;
    assign imem_we  = s2_valid;

    // Stage 1: capture the field bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_f     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid    <= 1'b1;
            s1_f.opcode <= opcode;
            s1_f.rd     <= rd;
            s1_f.funct3 <= funct3;
            s1_f.rs1    <= rs1;
            s1_f.rs2    <= rs2;
            s1_f.funct7 <= funct7;
            s1_f.imm    <= imm;
        end else if (s1_ret) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: hold the packed word while the write is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            imem_din <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s1_valid && !pk_err && s2_adv) begin
            s2_valid <= 1'b1;
            imem_din <= pk_word;
        end else if (wr_done) begin
            s2_valid <= 1'b0;
        end
    end

    // One-cycle error pulse as a rejected bundle leaves S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            err_valid <= err_fire;
            if (err_fire) err_code <= pk_code;
        end
    end

    // Write address and saturating write counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_addr <= BASE;
            count     <= '0;
        end else if (flush) begin
            imem_addr <= BASE;
            count     <= '0;
        end else if (wr_done) begin
            imem_addr <= imem_addr + 1'b1;
            if (count != 16'hFFFF) count <= count + 1'b1;
        end
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the core's instruction pre-decode path: accepts decoded RV32I fields (opcode, rd, rs1, rs2, funct3, funct7, byte-offset imm) over a valid/ready handshake.
- Range-checks the fields, packs them into a 32-bit instruction word, and streams words into instruction memory at an auto-incrementing word address.
- Used by the test-program loader and the self-test generator to build IMEM images in hardware.

Parameters:
XLEN, 32, instruction/immediate width
IMEM_AW, 14, IMEM word-address width
BASE_ADDR, 0, word address of first write after reset/flush

Ports:
clk  in  1  clock, all flops rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  sync: drop pipeline, address<=BASE_ADDR, count<=0
in_valid  in  1  field bundle valid
in_ready  out  1  encoder can accept bundle
opcode  in  7  RV32I opcode
rd  in  5  destination reg
funct3  in  3  funct3
rs1  in  5  source reg 1
rs2  in  5  source reg 2
funct7  in  7  funct7 (R-type, shift-immediates)
imm  in  XLEN  sign-extended immediate (byte offset for B/J, full value for U)
imem_we  out  1  write strobe, held until imem_ready
imem_addr  out  IMEM_AW  word address
imem_din  out  XLEN  encoded instruction
imem_ready  in  1  memory accepts write this cycle
err_valid  out  1  one-cycle pulse: bundle rejected
err_code  out  2  0 bad opcode, 1 imm out of range, 2 misaligned B/J offset, 3 bad shift fields
count  out  16  instructions written since reset/flush, saturating at 0xFFFF

Behaviour:
- Reset (async): both stage valids=0, imem_we=0, imem_din=0, imem_addr=BASE_ADDR, count=0, err_valid=0, err_code=0. in_ready=1 once out of reset.
- Stage 1 (check/pack): captures the bundle on in_valid&&in_ready. Computes the word and error combinationally from the registered fields.
- Stage 2 (output): holds the word. imem_we=S2 valid.
- A write completes on imem_we&&imem_ready. That cycle: imem_addr increments (wraps 2^IMEM_AW-1 -> 0, no error) and count increments (saturating).
- Latency: bundle accepted at edge N -> imem_we high from cycle N+2 at the earliest.
- Backpressure:
  - S2 advances when empty or writing.
  - S1 advances when empty or S2 advances.
  - in_ready = !S1valid || S1 advances. Two bundles may be outstanding.
- Errors, detected in S1:
  - Bundle is discarded, never written; address and count unchanged.
  - err_valid pulses one cycle as S1 retires; err_code is registered with it.
  - An errored S1 entry retires without waiting on S2.
- Formats ({} MSB-first, op = opcode):
  - R (0110011): {funct7,rs2,rs1,funct3,rd,op}.
  - I (0010011 non-shift, 0000011, 1100111): {imm[11:0],rs1,funct3,rd,op}. Requires -2048 <= imm <= 2047.
  - Shift (0010011, funct3 001/101): {funct7,imm[4:0],rs1,funct3,rd,op}. Requires imm[31:5]==0, funct7 in {0x00, 0x20}, and funct7==0x00 when funct3==001; else code 3.
  - S (0100011): {imm[11:5],rs2,rs1,funct3,imm[4:0],op}. Range as I.
  - B (1100011): {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}. Requires -4096 <= imm <= 4094 and imm[0]==0.
  - U (0110111, 0010111): {imm[31:12],rd,op}. Requires imm[11:0]==0, else code 1.
  - J (1101111): {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}. Requires -2^20 <= imm <= 2^20-2 and imm[0]==0.
  - Any other opcode: code 0.
- Error priority: misalignment (2) is reported over range (1).
- Flush:
  - Clears S1/S2 valids the same edge. A write completing in the flush cycle is still counted before count clears to 0.
  - Flush overrides acceptance; in_ready=0 during flush.
  - No err pulse for entries dropped by flush.
- Reset mid-write: imem_we drops immediately (async); the pending word is lost.

Decomposition:
- Shared package/defines:
  - Opcode constants (existing opcode header).
  - err_code encodings.
  - Format enum R/I/SH/S/B/U/J.
  - XLEN.
- One sub-module, instr_pack: pure combinational format select, bit packing and error generation.
- The top level holds the two pipeline stages, handshake, address counter and count.

Test Plan:
- addi x1,x0,5 (op 0010011, f3 0, imm 5), imem_ready=1 -> imem_din 0x00500093 at BASE_ADDR; count=1.
- sw x2,-4(x1), then beq x0,x0,-8, then jal x1,+2048, then lui x5 imm 0x12345000 back-to-back -> 0xFE20AE23, 0xFE000CE3, 0x001000EF, 0x123452B7 at consecutive addresses.
- beq imm=3, then addi imm=4096, then opcode 0x7F -> err_codes 2, 1, 0 as single-cycle pulses; no imem_we; address and count unchanged.
- imem_ready=0 for 5 cycles while 4 bundles are offered -> in_ready low after 2 accepted; words emitted in order with no loss or duplication once ready returns.
- BASE_ADDR=2^IMEM_AW-1: two writes -> second at address 0. Flush mid-stream -> next write at BASE_ADDR, count restarts at 1.
- Assert rst during a held imem_we -> outputs return to reset values asynchronously; first post-reset write lands at BASE_ADDR.
